// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: FSM encoding, default words and the
// jump-target helper used by the redirect logic.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_hold_buf.sv
// One-entry instruction buffer: keeps a fetched word while IF/ID is stalled.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    output logic        valid_o,
    output logic [31:0] data_o
);

    logic        valid_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i || drain_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the imem req/ready handshake, loads IF/ID and
// applies stalls, branch/jump redirects and single-slot flushes from ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        ifidWrite,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);

    localparam logic [31:0] ALIGN_MASK = ~32'h3;

    fetch_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic         buf_load, buf_drain, buf_clear, buf_valid;
    logic [31:0]  buf_data;
    logic         redirect, complete, accept;
    logic [31:0]  target, pc_plus4;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .clear_i (buf_clear),
        .data_i  (imem_rdata),
        .valid_o (buf_valid),
        .data_o  (buf_data)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        buf_load     = 1'b0;
        buf_drain    = 1'b0;
        buf_clear    = 1'b0;

        redirect = PCWrite && (jump || PCSrc);
        target   = jump ? jump_target(ifid_pc4_q, jump_index) : (branch_target & ALIGN_MASK);
        complete = req_q && imem_ready && (state_q == S_REQ || state_q == S_WAIT);
        accept   = PCWrite && ifidWrite;
        pc_plus4 = pc_q + 32'd4;

        if (ifidWrite) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end

        if (redirect) begin
            pc_d         = target;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            buf_clear    = 1'b1;
            case (state_q)
                S_REQ, S_WAIT: state_d = (req_q && !imem_ready) ? S_DROP : S_REQ;
                S_DROP:        state_d = imem_ready ? S_REQ : S_DROP;
                default:       state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ, S_WAIT: begin
                    if (complete && accept) begin
                        ifid_pc4_d   = pc_plus4;
                        ifid_instr_d = imem_rdata;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                        state_d      = S_REQ;
                    end else if (complete) begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end else if (req_q) begin
                        state_d = S_WAIT;
                    end
                end
                // The PC advances together with the IF/ID load, so a buffered
                // word only drains once the PC is free to move as well.
                S_HOLD: begin
                    if (accept && buf_valid) begin
                        ifid_pc4_d   = pc_plus4;
                        ifid_instr_d = buf_data;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                        buf_drain    = 1'b1;
                        state_d      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ready) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end

        req_d  = (state_d != S_HOLD);
        addr_d = (state_d == S_DROP) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC & ALIGN_MASK;
            addr_q       <= RESET_PC & ALIGN_MASK;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: a cycle table covering streaming,
// wait states, stalls, branch/jump redirects, plus a mid-WAIT reset sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCWrite = 1'b1, ifidWrite = 1'b1, PCSrc = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = '0;
    logic [25:0] jump_index = '0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata, ifid_pc4, ifid_instr;
    logic        ifid_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory contents: word at address a is a ^ 32'h8C00_0000.
    assign imem_rdata = imem_addr ^ 32'h8C00_0000;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCWrite       (PCWrite),
        .ifidWrite     (ifidWrite),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ifid_pc4      (ifid_pc4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid)
    );

    typedef struct {
        logic        pcw, ifw, src, jmp;
        logic [31:0] tgt;
        logic [25:0] jidx;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr, epc4, einstr;
        logic        evalid;
    } vec_t;

    function automatic vec_t mk(logic pcw, logic ifw, logic src, logic jmp,
                                logic [31:0] tgt, logic [25:0] jidx, logic rdy,
                                logic ereq, logic [31:0] eaddr, logic [31:0] epc4,
                                logic [31:0] einstr, logic evalid);
        vec_t v;
        v.pcw = pcw; v.ifw = ifw; v.src = src; v.jmp = jmp;
        v.tgt = tgt; v.jidx = jidx; v.rdy = rdy;
        v.ereq = ereq; v.eaddr = eaddr; v.epc4 = epc4;
        v.einstr = einstr; v.evalid = evalid;
        return v;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic check_all(input int row, input logic ereq, input logic [31:0] eaddr,
                             input logic [31:0] epc4, input logic [31:0] einstr,
                             input logic evalid);
        check("imem_req",   row, {31'd0, imem_req},   {31'd0, ereq});
        check("imem_addr",  row, imem_addr,           eaddr);
        check("ifid_pc4",   row, ifid_pc4,            epc4);
        check("ifid_instr", row, ifid_instr,          einstr);
        check("ifid_valid", row, {31'd0, ifid_valid}, {31'd0, evalid});
    endtask

    vec_t vt[26];

    initial begin
        //              pcw ifw src jmp tgt            jidx    rdy  req addr           pc4            instr          v
        vt[0]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   0, 32'h0,          32'h0,          32'h0,          0);
        vt[1]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h0,          32'h0,          32'h0,          0);
        vt[2]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h4,          32'h4,          32'h8C00_0000,  1);
        vt[3]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   1, 32'h8,          32'h8,          32'h8C00_0004,  1);
        vt[4]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   1, 32'h8,          32'h8,          32'h0,          0);
        vt[5]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   1, 32'h8,          32'h8,          32'h0,          0);
        vt[6]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h8,          32'h8,          32'h0,          0);
        vt[7]  = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'hC,          32'hC,          32'h8C00_0008,  1);
        vt[8]  = mk(0, 0, 0, 0, 32'h0,          26'h0,  1,   1, 32'h10,         32'h10,         32'h8C00_000C,  1);
        vt[9]  = mk(0, 0, 0, 0, 32'h0,          26'h0,  0,   0, 32'h10,         32'h10,         32'h8C00_000C,  1);
        vt[10] = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   0, 32'h10,         32'h10,         32'h8C00_000C,  1);
        vt[11] = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h14,         32'h14,         32'h8C00_0010,  1);
        vt[12] = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h18,         32'h18,         32'h8C00_0014,  1);
        vt[13] = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h1C,         32'h1C,         32'h8C00_0018,  1);
        vt[14] = mk(1, 1, 1, 0, 32'h40,         26'h0,  0,   1, 32'h20,         32'h20,         32'h8C00_001C,  1);
        vt[15] = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   1, 32'h20,         32'h20,         32'h0,          0);
        vt[16] = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h20,         32'h20,         32'h0,          0);
        vt[17] = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h40,         32'h20,         32'h0,          0);
        vt[18] = mk(1, 1, 1, 0, 32'h1000_0004,  26'h0,  1,   1, 32'h44,         32'h44,         32'h8C00_0040,  1);
        vt[19] = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h1000_0004,  32'h44,         32'h0,          0);
        vt[20] = mk(1, 1, 1, 1, 32'h80,         26'h10, 1,   1, 32'h1000_0008,  32'h1000_0008,  32'h9C00_0004,  1);
        vt[21] = mk(1, 1, 0, 0, 32'h0,          26'h0,  1,   1, 32'h1000_0040,  32'h1000_0008,  32'h0,          0);
        vt[22] = mk(0, 0, 1, 0, 32'h80,         26'h0,  1,   1, 32'h1000_0044,  32'h1000_0044,  32'h9C00_0040,  1);
        vt[23] = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   0, 32'h1000_0044,  32'h1000_0044,  32'h9C00_0040,  1);
        vt[24] = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   1, 32'h1000_0048,  32'h1000_0048,  32'h9C00_0044,  1);
        vt[25] = mk(1, 1, 0, 0, 32'h0,          26'h0,  0,   1, 32'h1000_0048,  32'h1000_0048,  32'h0,          0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            PCWrite       = vt[i].pcw;
            ifidWrite     = vt[i].ifw;
            PCSrc         = vt[i].src;
            jump          = vt[i].jmp;
            branch_target = vt[i].tgt;
            jump_index    = vt[i].jidx;
            imem_ready    = vt[i].rdy;
            #1;
            check_all(i, vt[i].ereq, vt[i].eaddr, vt[i].epc4, vt[i].einstr, vt[i].evalid);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset while a request is waiting: outputs clear at once.
        PCWrite = 1'b1; ifidWrite = 1'b1; PCSrc = 1'b0; jump = 1'b0; imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(100, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        #1;
        check_all(101, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_all(102, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_all(103, 1'b1, 32'h4, 32'h4, 32'h8C00_0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
